// File: rtl/ipq_pkg.sv
// ipq_pkg: shared types and constants for the instruction prefetch queue.
//   ipq_entry_t  one buffered instruction together with the PC it was fetched from
//   ibus_req_t   request towards the instruction bus {valid, addr}
//   ibus_resp_t  response from the instruction bus {addr_ok, data_ok, data}
//   ipq_state_e  request FSM: RUN (free to issue) / HOLD (request waiting for addr_ok)
package ipq_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ipq_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic {
    RUN,
    HOLD
  } ipq_state_e;

endpackage

// File: rtl/ipq_fifo.sv
// ipq_fifo: small synchronous FIFO with a flush input.
//   clk, resetn  clock and asynchronous active-low reset
//   flush        empties the FIFO this cycle; wins over push and pop
//   push, pushData  write one word (ignored when full)
//   pop          drop the head word (ignored when empty)
//   headData     current head word (combinational read of the storage)
//   empty, full, count  occupancy status
// DEPTH must be a power of two: the pointers carry one extra wrap bit and
// simply roll over, so full/empty are told apart by that bit alone.
module ipq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count    = wrPtr - rdPtr;
  assign headData = mem[rdPtr[AW-1:0]];

  // Pointer update: flush resets both pointers, otherwise push and pop
  // advance independently so a simultaneous push/pop keeps the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read out before it has been written.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: fetch front end between the instruction bus and decode.
//   clk, resetn      clock, asynchronous active-low reset
//   ireq             {valid, addr} request to the instruction bus
//   iresp            {addr_ok, data_ok, data} response from the instruction bus
//   redirect_valid   flush the queue and restart fetch at redirect_pc
//   redirect_pc      new word-aligned fetch address
//   out_valid, out_pc, out_instr, out_ready   valid/ready hand-off to decode
// Build option: define IPQ_BYPASS_EN to forward a response straight to decode
// in the same cycle when the queue is empty; otherwise every output comes
// from the queue and data_ok -> out_valid takes one cycle.
module inst_prefetch_queue import ipq_pkg::*; #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = ipq_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int QW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  ipq_state_e  state, stateNext;
  logic [31:0] fetchPc;
  logic [31:0] holdAddr;
  logic        staleHold;
  logic [OW-1:0] drop;

  logic [QW-1:0] qCount;
  logic          qEmpty, qFull, qPush, qPop;
  ipq_entry_t    qHead, qIn;
  logic [OW-1:0] outst;
  logic          tagEmpty, tagFull;
  logic [31:0]   tagHead;

  logic hs, dataOk, discard, credit;

  assign hs      = ireq.valid && iresp.addr_ok;
  assign dataOk  = iresp.data_ok && !tagEmpty;
  // Anything returning while a redirect is in progress or while stale
  // requests are still owed belongs to the old instruction stream.
  assign discard = redirect_valid || (drop != '0);
  // Queued entries plus in-flight requests may never exceed the queue size,
  // which is what lets data_ok be accepted without back-pressure.
  assign credit  = ((32'(qCount) + 32'(outst)) < DEPTH) && !tagFull;
  assign qIn     = '{pc: tagHead, instr: iresp.data};

  // Request FSM, combinational half: RUN issues whenever credit allows;
  // HOLD keeps the very same request on the bus until it is accepted.
  always_comb begin
    stateNext  = state;
    ireq.valid = 1'b0;
    ireq.addr  = fetchPc;
    case (state)
      RUN: begin
        if (resetn && credit && !redirect_valid) begin
          ireq.valid = 1'b1;
          if (!iresp.addr_ok) stateNext = HOLD;
        end
      end
      HOLD: begin
        ireq.valid = 1'b1;
        ireq.addr  = holdAddr;
        if (iresp.addr_ok) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // Fetch PC, held request and drop bookkeeping. On a redirect every request
  // still owed after this cycle is dropped; a held request that has not been
  // accepted yet is marked stale and joins the drop count when accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RUN;
      fetchPc   <= RESET_PC;
      holdAddr  <= RESET_PC;
      staleHold <= 1'b0;
      drop      <= '0;
    end else begin
      state <= stateNext;
      if (state == RUN && ireq.valid && !iresp.addr_ok) holdAddr <= fetchPc;
      if (redirect_valid) begin
        fetchPc   <= redirect_pc;
        drop      <= outst + OW'(hs) - OW'(dataOk);
        staleHold <= (state == HOLD) && !iresp.addr_ok;
      end else begin
        if (hs && !staleHold) fetchPc <= fetchPc + 32'd4;
        drop <= drop + OW'(hs && staleHold) - OW'(dataOk && (drop != '0));
        if (hs) staleHold <= 1'b0;
      end
    end
  end

`ifdef IPQ_BYPASS_EN
  logic bypass;
  assign bypass    = qEmpty && dataOk && !discard;
  assign out_valid = !qEmpty || bypass;
  assign out_pc    = !qEmpty ? qHead.pc    : (bypass ? tagHead    : 32'd0);
  assign out_instr = !qEmpty ? qHead.instr : (bypass ? iresp.data : 32'd0);
  assign qPush     = dataOk && !discard && !qFull && !(bypass && out_ready);
`else
  assign out_valid = !qEmpty;
  assign out_pc    = qEmpty ? 32'd0 : qHead.pc;
  assign out_instr = qEmpty ? 32'd0 : qHead.instr;
  assign qPush     = dataOk && !discard && !qFull;
`endif

  assign qPop = !qEmpty && out_ready && !redirect_valid;

  ipq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ipq_entry_t))) entryQueue (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect_valid),
    .push     (qPush),
    .pushData (qIn),
    .pop      (qPop),
    .headData (qHead),
    .empty    (qEmpty),
    .full     (qFull),
    .count    (qCount)
  );

  // Tags of accepted requests; responses come back in issue order, so the
  // head tag always names the returning word. Its occupancy is the
  // outstanding-request count. Never flushed: stale responses still arrive.
  ipq_fifo #(.DEPTH(MAX_OUTST), .WIDTH(32)) tagFifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (1'b0),
    .push     (hs),
    .pushData (ireq.addr),
    .pop      (dataOk),
    .headData (tagHead),
    .empty    (tagEmpty),
    .full     (tagFull),
    .count    (outst)
  );

endmodule
